// File: rtl/io_uart_tx_peripheral.sv
// Memory-mapped 8N1 UART transmitter with a small TX FIFO.
// Registers: TXDATA (push byte) and STATUS (count/ovf/busy/empty/full).
`timescale 1ns/1ps
module io_uart_tx_peripheral #(
   parameter int          INPUT_CLOCK_RATE = 33_333_333,
   parameter int          BAUD_RATE        = 19_200,
   parameter logic [31:0] BASE_ADDRESS     = 32'h00007f40,
   parameter int          FIFO_DEPTH       = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] address,
   input  logic        MemWrite,
   input  logic        MemRead,
   input  logic [31:0] io_memory_write,
   output logic [31:0] io_memory_read,
   output logic        valid_io_read,
   output logic        RsRx,
   output logic        tx_busy
);
   localparam int RAW_DIV  = INPUT_CLOCK_RATE / BAUD_RATE;
   localparam int BAUD_DIV = (RAW_DIV < 2) ? 2 : RAW_DIV;
   localparam int CW       = $clog2(BAUD_DIV);
   localparam int AW       = $clog2(FIFO_DEPTH);
   localparam int NW       = AW + 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;
   localparam logic [1:0] S_STOP  = 2'd3;

   logic [1:0]    state;
   logic [CW-1:0] baud_cnt;
   logic [2:0]    idx;
   logic [7:0]    shift;
   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic [NW-1:0] count;
   logic          ovf;

   logic       hit;
   logic [1:0] sel;
   logic       wr_tx;
   logic       wr_st;
   logic       empty;
   logic       full;
   logic       baud_end;
   logic       pop;
   logic       push;
   logic       drop;
   logic [31:0] status;

   assign hit      = (address[31:4] == BASE_ADDRESS[31:4]);
   assign sel      = address[3:2];
   assign wr_tx    = MemWrite && hit && (sel == 2'd0);
   assign wr_st    = MemWrite && hit && (sel == 2'd1);
   assign empty    = (count == '0);
   assign full     = (count == NW'(FIFO_DEPTH));
   assign baud_end = (baud_cnt == CW'(BAUD_DIV - 1));
   assign tx_busy  = (state != S_IDLE);

   // Pop only at frame boundaries so a new frame starts with no idle gap.
   assign pop  = !empty && ((state == S_IDLE) || (state == S_STOP && baud_end));
   assign push = wr_tx && (!full || pop);
   assign drop = wr_tx && full && !pop;

   assign status = {24'b0, 4'(count), ovf, tx_busy, empty, full};

   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= io_memory_write[7:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
         ovf   <= 1'b0;
      end else begin
         if (push) wptr <= wptr + AW'(1);
         if (pop)  rptr <= rptr + AW'(1);
         if (push && !pop)      count <= count + NW'(1);
         else if (pop && !push) count <= count - NW'(1);
         if (drop)       ovf <= 1'b1;
         else if (wr_st) ovf <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         baud_cnt <= '0;
         idx      <= '0;
         shift    <= '0;
         RsRx     <= 1'b1;
      end else if (state == S_IDLE) begin
         baud_cnt <= '0;
         if (pop) begin
            state <= S_START;
            shift <= mem[rptr];
            RsRx  <= 1'b0;
         end
      end else if (!baud_end) begin
         baud_cnt <= baud_cnt + CW'(1);
      end else begin
         baud_cnt <= '0;
         case (state)
            S_START: begin
               state <= S_DATA;
               idx   <= '0;
               RsRx  <= shift[0];
            end
            S_DATA: begin
               if (idx == 3'd7) begin
                  state <= S_STOP;
                  RsRx  <= 1'b1;
               end else begin
                  idx   <= idx + 3'd1;
                  RsRx  <= shift[1];
                  shift <= shift >> 1;
               end
            end
            default: begin
               if (pop) begin
                  state <= S_START;
                  shift <= mem[rptr];
                  RsRx  <= 1'b0;
               end else begin
                  state <= S_IDLE;
                  RsRx  <= 1'b1;
               end
            end
         endcase
      end
   end

   // Read data reflects state before any same-cycle write takes effect.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         io_memory_read <= '0;
         valid_io_read  <= 1'b0;
      end else begin
         valid_io_read <= MemRead && hit;
         if (MemRead && hit && sel == 2'd1) io_memory_read <= status;
         else                               io_memory_read <= '0;
      end
   end
endmodule

// File: tb/tb_io_uart_tx_peripheral.sv
// Directed/randomized bench for io_uart_tx_peripheral with a frame decoder
// on RsRx and a byte-queue reference model of what must appear on the line.
`timescale 1ns/1ps
module tb_io_uart_tx_peripheral;
   localparam logic [31:0] BASE  = 32'h00007f40;
   localparam int          DEPTH = 4;
   localparam int          BIT   = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] address;
   logic        MemWrite;
   logic        MemRead;
   logic [31:0] io_memory_write;
   logic [31:0] io_memory_read;
   logic        valid_io_read;
   logic        RsRx;
   logic        tx_busy;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int frames_done = 0;
   logic mon_en;
   logic [7:0] exp_q[$];
   int starts[$];

   io_uart_tx_peripheral #(
      .INPUT_CLOCK_RATE(16),
      .BAUD_RATE(1),
      .BASE_ADDRESS(BASE),
      .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk),
      .rst(rst),
      .address(address),
      .MemWrite(MemWrite),
      .MemRead(MemRead),
      .io_memory_write(io_memory_write),
      .io_memory_read(io_memory_read),
      .valid_io_read(valid_io_read),
      .RsRx(RsRx),
      .tx_busy(tx_busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h required %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] st(input int cnt, input logic ov,
                                      input logic busy);
      return {24'b0, 4'(cnt), ov, busy, cnt == 0, cnt == DEPTH};
   endfunction

   // Line decoder: samples each bit near its centre.
   always begin : monitor
      logic [7:0] b;
      @(negedge RsRx);
      if (mon_en && !rst) begin
         @(negedge clk);
         starts.push_back(cyc);
         repeat (7) @(negedge clk);
         check("start_bit", {31'b0, RsRx}, 32'd0);
         for (int i = 0; i < 8; i++) begin
            repeat (BIT) @(negedge clk);
            b[i] = RsRx;
         end
         repeat (BIT) @(negedge clk);
         check("stop_bit", {31'b0, RsRx}, 32'd1);
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL unexpected_frame: observed %h required none", b);
         end else begin
            check("frame_data", {24'b0, b}, {24'b0, exp_q.pop_front()});
         end
         frames_done++;
      end
   end

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      address = a;
      io_memory_write = d;
      MemWrite = 1'b1;
      @(posedge clk); #1;
      MemWrite = 1'b0;
   endtask

   task automatic wr_burst(input logic [7:0] d[$]);
      address = BASE;
      MemWrite = 1'b1;
      foreach (d[i]) begin
         io_memory_write = {24'b0, d[i]};
         @(posedge clk); #1;
      end
      MemWrite = 1'b0;
   endtask

   task automatic rd(input string tag, input logic [31:0] a,
                     input logic exp_v, input logic [31:0] exp_d);
      address = a;
      MemRead = 1'b1;
      @(posedge clk); #1;
      MemRead = 1'b0;
      check({tag, "_valid"}, {31'b0, valid_io_read}, {31'b0, exp_v});
      check({tag, "_data"}, io_memory_read, exp_d);
      @(posedge clk); #1;
      check({tag, "_valid_after"}, {31'b0, valid_io_read}, 32'd0);
   endtask

   task automatic wait_fall(output int c);
      int k = 0;
      while (RsRx !== 1'b0 && k < 50) begin
         @(posedge clk); #1;
         k++;
      end
      check("start_seen", {31'b0, RsRx}, 32'd0);
      c = cyc;
   endtask

   task automatic wait_cyc(input int t);
      while (cyc < t) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic wait_frames(input int target);
      int k = 0;
      while (frames_done < target && k < 170 * DEPTH * 3) begin
         @(posedge clk); #1;
         k++;
      end
      check("frames_done", frames_done, target);
   endtask

   initial begin
      int c;
      int acc;
      logic [7:0] b;
      logic [7:0] q[$];
      rst = 1'b1;
      address = '0;
      MemWrite = 1'b0;
      MemRead = 1'b0;
      io_memory_write = '0;
      mon_en = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_read", io_memory_read, 32'd0);
      check("rst_valid", {31'b0, valid_io_read}, 32'd0);
      check("rst_rsrx", {31'b0, RsRx}, 32'd1);
      check("rst_busy", {31'b0, tx_busy}, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      rd("status_idle", BASE + 4, 1'b1, st(0, 0, 0));

      // Single 0x55 frame with timing.
      exp_q.push_back(8'h55);
      wr(BASE, 32'h55);
      @(posedge clk); #1;
      check("start_latency", {31'b0, RsRx}, 32'd0);
      check("busy_rise", {31'b0, tx_busy}, 32'd1);
      c = cyc;
      rd("status_busy", BASE + 4, 1'b1, st(0, 0, 1));
      wait_cyc(c + 10 * BIT - 1);
      check("busy_last", {31'b0, tx_busy}, 32'd1);
      @(posedge clk); #1;
      check("busy_fall", {31'b0, tx_busy}, 32'd0);
      check("idle_line", {31'b0, RsRx}, 32'd1);
      wait_frames(1);

      // Five consecutive writes: all accepted, frames back to back.
      starts.delete();
      q.delete();
      for (int i = 0; i < 5; i++) begin
         b = 8'($urandom);
         q.push_back(b);
         exp_q.push_back(b);
      end
      wr_burst(q);
      wait_frames(6);
      for (int i = 0; i + 1 < starts.size(); i++)
         check("frame_gap", starts[i + 1] - starts[i], 10 * BIT);

      // Overflow while a frame is shifting.
      b = 8'($urandom);
      exp_q.push_back(b);
      wr(BASE, {24'b0, b});
      wait_fall(c);
      q.delete();
      for (int i = 0; i < 6; i++) q.push_back(8'($urandom));
      acc = (q.size() < DEPTH) ? q.size() : DEPTH;
      for (int i = 0; i < acc; i++) exp_q.push_back(q[i]);
      wr_burst(q);
      rd("status_ovf", BASE + 4, 1'b1, st(DEPTH, 1, 1));
      wr(BASE + 4, $urandom);
      rd("status_clr", BASE + 4, 1'b1, st(DEPTH, 0, 1));
      rd("txdata_rd", BASE, 1'b1, 32'd0);
      rd("reserved_rd", BASE + 8, 1'b1, 32'd0);
      rd("outside_rd", 32'h00002000, 1'b0, 32'd0);
      wait_frames(7 + acc);

      // Push coinciding with the STOP->START pop while full.
      b = 8'($urandom);
      exp_q.push_back(b);
      wr(BASE, {24'b0, b});
      wait_fall(c);
      q.delete();
      for (int i = 0; i < DEPTH; i++) begin
         q.push_back(8'($urandom));
         exp_q.push_back(q[i]);
      end
      wr_burst(q);
      wait_cyc(c + 10 * BIT - 1);
      b = 8'($urandom);
      exp_q.push_back(b);
      wr(BASE, {24'b0, b});
      rd("status_pushpop", BASE + 4, 1'b1, st(DEPTH, 0, 1));
      wait_frames(7 + acc + DEPTH + 2);

      // Reset in the middle of data bit 3.
      mon_en = 1'b0;
      b = 8'($urandom) & 8'hF7;
      wr(BASE, {24'b0, b});
      wait_fall(c);
      q.delete();
      q.push_back(8'($urandom));
      q.push_back(8'($urandom));
      wr_burst(q);
      wait_cyc(c + 70);
      check("bit3_low", {31'b0, RsRx}, 32'd0);
      #2 rst = 1'b1;
      #1;
      check("rst_mid_rsrx", {31'b0, RsRx}, 32'd1);
      check("rst_mid_busy", {31'b0, tx_busy}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      rd("status_after_rst", BASE + 4, 1'b1, st(0, 0, 0));
      mon_en = 1'b1;
      b = 8'($urandom);
      exp_q.push_back(b);
      wr(BASE, {24'b0, b});
      wait_frames(7 + acc + DEPTH + 3);
      repeat (200) @(posedge clk);
      #1;
      check("queue_drained", exp_q.size(), 0);
      check("frame_total", frames_done, 7 + acc + DEPTH + 3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
